// File: rtl/noc_params.sv
// Router-wide sizing shared by the allocator and its arbiters.
package noc_params;

   localparam int PORT_NUM  = 5;
   localparam int VC_NUM    = 2;
   localparam int PORT_SIZE = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
   localparam int VC_SIZE   = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   // Only PORT_NUM encodings are ever driven onto a port_t.
   typedef logic [PORT_SIZE-1:0] port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter: the first request at or after the pointer wins,
// and the pointer moves just past the winner only when the caller confirms the grant.
module round_robin_arbiter #(
   parameter int N = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     request_i,
   input  logic             update_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             valid_o
);

   logic [IDX_W-1:0] r_ptr;
   logic [IDX_W-1:0] w_idx;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      valid_o     = 1'b0;
      w_idx       = '0;
      for (int k = 0; k < N; k++) begin
         w_idx = IDX_W'((int'(r_ptr) + k) % N);
         if (!valid_o && request_i[w_idx]) begin
            valid_o        = 1'b1;
            grant_idx_o    = w_idx;
            grant_o[w_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (update_i && valid_o) begin
         r_ptr <= (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + IDX_W'(1);
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first switch allocator: per-input VC arbitration, then
// per-output port arbitration, with a registered crossbar setting for traversal.
module switch_allocator
   import noc_params::port_t;
   import noc_params::PORT_SIZE;
   import noc_params::VC_SIZE;
#(
   parameter int PORT_NUM = noc_params::PORT_NUM,
   parameter int VC_NUM   = noc_params::VC_NUM
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          request_i,
   input  port_t [PORT_NUM-1:0][VC_NUM-1:0]          out_port_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
   input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          on_off_i,
   output logic  [PORT_NUM-1:0]                      valid_sel_o,
   output logic  [PORT_NUM-1:0][VC_SIZE-1:0]         vc_sel_o,
   output logic  [PORT_NUM-1:0]                      xb_valid_o,
   output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]       xb_sel_o,
   output logic  [PORT_NUM-1:0][VC_SIZE-1:0]         xb_vc_o
);

   logic [PORT_NUM-1:0][VC_NUM-1:0]    w_elig;
   logic [PORT_NUM-1:0][VC_NUM-1:0]    w_s1_grant;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_s1_idx;
   logic [PORT_NUM-1:0]                w_s1_valid;
   port_t [PORT_NUM-1:0]               w_s1_port;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   w_s1_dvc;

   logic [PORT_NUM-1:0][PORT_NUM-1:0]  w_s2_req;
   logic [PORT_NUM-1:0][PORT_NUM-1:0]  w_s2_grant;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] w_s2_idx;
   logic [PORT_NUM-1:0]                w_s2_valid;

   logic [PORT_NUM-1:0]                w_grant_in;

   logic [PORT_NUM-1:0]                r_xb_valid;
   logic [PORT_NUM-1:0][PORT_SIZE-1:0] r_xb_sel;
   logic [PORT_NUM-1:0][VC_SIZE-1:0]   r_xb_vc;

   genvar gi, gv;
   generate
      for (gi = 0; gi < PORT_NUM; gi++) begin : g_in
         for (gv = 0; gv < VC_NUM; gv++) begin : g_vc
            // Downstream credit is checked against the VC's own route, so a
            // blocked VC steps aside and lets a sibling VC compete instead.
            assign w_elig[gi][gv] = request_i[gi][gv]
                                  & on_off_i[out_port_i[gi][gv]][downstream_vc_i[gi][gv]];
         end

         round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
            .clk        (clk),
            .rst        (rst),
            .request_i  (w_elig[gi]),
            .update_i   (w_grant_in[gi]),
            .grant_o    (w_s1_grant[gi]),
            .grant_idx_o(w_s1_idx[gi]),
            .valid_o    (w_s1_valid[gi])
         );

         always_comb begin
            w_s1_port[gi] = '0;
            w_s1_dvc[gi]  = '0;
            for (int v = 0; v < VC_NUM; v++) begin
               if (w_s1_grant[gi][v]) begin
                  w_s1_port[gi] = w_s1_port[gi] | out_port_i[gi][v];
                  w_s1_dvc[gi]  = w_s1_dvc[gi] | downstream_vc_i[gi][v];
               end
            end
         end
      end

      for (gi = 0; gi < PORT_NUM; gi++) begin : g_out
         for (gv = 0; gv < PORT_NUM; gv++) begin : g_req
            assign w_s2_req[gi][gv] = w_s1_valid[gv] && (w_s1_port[gv] == PORT_SIZE'(gi));
         end

         round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
            .clk        (clk),
            .rst        (rst),
            .request_i  (w_s2_req[gi]),
            .update_i   (w_s2_valid[gi]),
            .grant_o    (w_s2_grant[gi]),
            .grant_idx_o(w_s2_idx[gi]),
            .valid_o    (w_s2_valid[gi])
         );

         // Unused outputs keep their last selection so the datapath mux stays quiet.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_xb_valid[gi] <= 1'b0;
               r_xb_sel[gi]   <= '0;
               r_xb_vc[gi]    <= '0;
            end else begin
               r_xb_valid[gi] <= w_s2_valid[gi];
               if (w_s2_valid[gi]) begin
                  r_xb_sel[gi] <= w_s2_idx[gi];
                  r_xb_vc[gi]  <= w_s1_dvc[w_s2_idx[gi]];
               end
            end
         end
      end

      for (gi = 0; gi < PORT_NUM; gi++) begin : g_grant
         always_comb begin
            w_grant_in[gi] = 1'b0;
            for (int o = 0; o < PORT_NUM; o++) begin
               w_grant_in[gi] = w_grant_in[gi] | w_s2_grant[o][gi];
            end
         end

         assign valid_sel_o[gi] = rst & w_grant_in[gi];
         assign vc_sel_o[gi]    = (rst && w_grant_in[gi]) ? w_s1_idx[gi] : '0;
      end
   endgenerate

   assign xb_valid_o = r_xb_valid;
   assign xb_sel_o   = r_xb_sel;
   assign xb_vc_o    = r_xb_vc;

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed table, hand sequences and
// randomized traffic against a behavioural allocation model.
module tb_switch_allocator;
   import noc_params::port_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic  [4:0][1:0]      request_i;
   port_t [4:0][1:0]      out_port_i;
   logic  [4:0][1:0][0:0] downstream_vc_i;
   logic  [4:0][1:0]      on_off_i;
   logic  [4:0]           valid_sel_o;
   logic  [4:0][0:0]      vc_sel_o;
   logic  [4:0]           xb_valid_o;
   logic  [4:0][2:0]      xb_sel_o;
   logic  [4:0][0:0]      xb_vc_o;

   switch_allocator dut (
      .clk            (clk),
      .rst            (rst),
      .request_i      (request_i),
      .out_port_i     (out_port_i),
      .downstream_vc_i(downstream_vc_i),
      .on_off_i       (on_off_i),
      .valid_sel_o    (valid_sel_o),
      .vc_sel_o       (vc_sel_o),
      .xb_valid_o     (xb_valid_o),
      .xb_sel_o       (xb_sel_o),
      .xb_vc_o        (xb_vc_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_cyc    = 0;

   // Reference state: round-robin pointers and the expected crossbar register.
   int m_in_ptr[5];
   int m_out_ptr[5];
   int m_w[5];
   int m_g[5];
   logic [4:0]      exp_xbv;
   logic [4:0][2:0] exp_sel;
   logic [4:0][0:0] exp_vcx;

   logic [4:0] cap_valid, cap_vc, cap_xbv;

   typedef struct {
      bit         rst_first;
      logic [9:0] req;
      logic [29:0] op;
      logic [9:0] dvc;
      logic [9:0] onoff;
      logic [4:0] exp_valid;
      logic [4:0] exp_vc;
      logic [4:0] exp_xbv;
   } vec_t;

   vec_t tbl[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n_cyc);
      end
   endtask

   function automatic logic [9:0] rq(input int i, input int v);
      logic [9:0] r;
      r = '0;
      r[i*2+v] = 1'b1;
      return r;
   endfunction

   function automatic logic [29:0] op1(input int i, input int v, input int p);
      logic [29:0] r;
      r = '0;
      r[(i*2+v)*3 +: 3] = 3'(p);
      return r;
   endfunction

   task automatic set_row(input int n, input bit rf, input logic [9:0] req, input logic [29:0] op,
                          input logic [9:0] dvc, input logic [9:0] onoff,
                          input logic [4:0] ev, input logic [4:0] evc, input logic [4:0] exv);
      tbl[n].rst_first = rf;
      tbl[n].req       = req;
      tbl[n].op        = op;
      tbl[n].dvc       = dvc;
      tbl[n].onoff     = onoff;
      tbl[n].exp_valid = ev;
      tbl[n].exp_vc    = evc;
      tbl[n].exp_xbv   = exv;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 5; k++) begin
         m_in_ptr[k]  = 0;
         m_out_ptr[k] = 0;
      end
      exp_xbv = '0;
      exp_sel = '0;
      exp_vcx = '0;
   endtask

   // Input first: each input offers one eligible VC; each output then takes one offer.
   task automatic model_eval();
      int v, c, o;
      for (int i = 0; i < 5; i++) begin
         m_w[i] = -1;
         for (int k = 0; k < 2; k++) begin
            v = (m_in_ptr[i] + k) % 2;
            if (m_w[i] < 0 && request_i[i][v] && on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]])
               m_w[i] = v;
         end
      end
      for (o = 0; o < 5; o++) begin
         m_g[o] = -1;
         for (int k = 0; k < 5; k++) begin
            c = (m_out_ptr[o] + k) % 5;
            if (m_g[o] < 0 && m_w[c] >= 0 && int'(out_port_i[c][m_w[c]]) == o)
               m_g[o] = c;
         end
      end
   endtask

   task automatic check_zero(input string tag);
      logic [4:0] vcs;
      for (int i = 0; i < 5; i++) vcs[i] = vc_sel_o[i][0];
      check({tag, "_valid_sel"}, valid_sel_o, 0);
      check({tag, "_vc_sel"}, vcs, 0);
      check({tag, "_xb_valid"}, xb_valid_o, 0);
      check({tag, "_xb_sel"}, xb_sel_o, 0);
      check({tag, "_xb_vc"}, xb_vc_o, 0);
   endtask

   task automatic randomize_inputs();
      request_i = 10'($urandom);
      on_off_i  = 10'($urandom | $urandom);
      downstream_vc_i = 10'($urandom);
      for (int i = 0; i < 5; i++)
         for (int v = 0; v < 2; v++)
            out_port_i[i][v] = 3'($urandom_range(0, 4));
   endtask

   // Entered and left one time unit after a rising edge.
   task automatic reset_pulse();
      randomize_inputs();
      rst = 1'b0;
      #1;
      check_zero("rst_async");
      @(posedge clk);
      #1;
      check_zero("rst_hold");
      request_i = '0;
      rst = 1'b1;
      model_reset();
   endtask

   // One allocation cycle: grants checked mid-cycle, crossbar just after the edge.
   task automatic cycle();
      logic [4:0] mv, mvc, vcs;
      #2;
      model_eval();
      mv = '0;
      mvc = '0;
      for (int o = 0; o < 5; o++) begin
         if (m_g[o] >= 0) begin
            mv[m_g[o]]  = 1'b1;
            mvc[m_g[o]] = 1'(m_w[m_g[o]]);
         end
      end
      for (int i = 0; i < 5; i++) vcs[i] = vc_sel_o[i][0];
      check("valid_sel", valid_sel_o, mv);
      check("vc_sel", vcs, mvc);
      cap_valid = valid_sel_o;
      cap_vc    = vcs;
      @(posedge clk);
      for (int o = 0; o < 5; o++) begin
         if (m_g[o] >= 0) begin
            exp_xbv[o] = 1'b1;
            exp_sel[o] = 3'(m_g[o]);
            exp_vcx[o] = downstream_vc_i[m_g[o]][m_w[m_g[o]]];
            m_out_ptr[o] = (m_g[o] + 1) % 5;
            m_in_ptr[m_g[o]] = (m_w[m_g[o]] + 1) % 2;
         end else begin
            exp_xbv[o] = 1'b0;
         end
      end
      #1;
      check("xb_valid", xb_valid_o, exp_xbv);
      check("xb_sel", xb_sel_o, exp_sel);
      check("xb_vc", xb_vc_o, exp_vcx);
      cap_xbv = xb_valid_o;
      $display("cyc %0d req=%h onoff=%h valid=%b vc=%b xbv=%b", n_cyc, request_i, on_off_i,
               cap_valid, cap_vc, cap_xbv);
      n_cyc++;
   endtask

   initial begin
      logic [9:0] all_on;
      logic [29:0] fair_op, cont_op, lose_op;
      int s;
      all_on = 10'h3FF;
      rst = 1'b0;
      request_i = '0;
      out_port_i = '0;
      downstream_vc_i = '0;
      on_off_i = '0;
      model_reset();
      @(posedge clk);
      #1;
      reset_pulse();

      fair_op = op1(1, 0, 0) | op1(1, 1, 1);
      cont_op = op1(0, 0, 1) | op1(3, 0, 1) | op1(4, 0, 1);
      lose_op = op1(0, 0, 0) | op1(2, 0, 0) | op1(2, 1, 3);
      set_row(0,  0, rq(0,1), op1(0,1,2), '0, all_on, 5'b00001, 5'b00001, 5'b00100);
      set_row(1,  0, rq(1,0)|rq(1,1), fair_op, '0, all_on, 5'b00010, 5'b00000, 5'b00001);
      set_row(2,  0, rq(1,0)|rq(1,1), fair_op, '0, all_on, 5'b00010, 5'b00010, 5'b00010);
      set_row(3,  0, rq(1,0)|rq(1,1), fair_op, '0, all_on, 5'b00010, 5'b00000, 5'b00001);
      set_row(4,  0, rq(1,0)|rq(1,1), fair_op, '0, all_on, 5'b00010, 5'b00010, 5'b00010);
      set_row(5,  1, rq(0,0)|rq(3,0)|rq(4,0), cont_op, '0, all_on, 5'b00001, 5'b00000, 5'b00010);
      set_row(6,  0, rq(0,0)|rq(3,0)|rq(4,0), cont_op, '0, all_on, 5'b01000, 5'b00000, 5'b00010);
      set_row(7,  0, rq(0,0)|rq(3,0)|rq(4,0), cont_op, '0, all_on, 5'b10000, 5'b00000, 5'b00010);
      set_row(8,  0, rq(0,0)|rq(3,0)|rq(4,0), cont_op, '0, all_on, 5'b00001, 5'b00000, 5'b00010);
      set_row(9,  0, rq(0,0)|rq(3,0)|rq(4,0), cont_op, '0, all_on, 5'b01000, 5'b00000, 5'b00010);
      set_row(10, 0, rq(0,0)|rq(3,0)|rq(4,0), cont_op, '0, all_on, 5'b10000, 5'b00000, 5'b00010);
      set_row(11, 1, rq(0,0)|rq(2,0)|rq(2,1), lose_op, '0, all_on, 5'b00001, 5'b00000, 5'b00001);
      set_row(12, 0, rq(2,0)|rq(2,1), lose_op, '0, all_on, 5'b00100, 5'b00000, 5'b00001);
      set_row(13, 1, rq(1,0), op1(1,0,4), rq(1,0), 10'h1FF, 5'b00000, 5'b00000, 5'b00000);
      set_row(14, 0, rq(1,0), op1(1,0,4), rq(1,0), all_on, 5'b00010, 5'b00000, 5'b10000);

      for (int n = 0; n < 15; n++) begin
         if (tbl[n].rst_first) reset_pulse();
         request_i       = tbl[n].req;
         out_port_i      = tbl[n].op;
         downstream_vc_i = tbl[n].dvc;
         on_off_i        = tbl[n].onoff;
         cycle();
         check($sformatf("tbl%0d_valid", n), cap_valid, tbl[n].exp_valid);
         check($sformatf("tbl%0d_vc", n), cap_vc, tbl[n].exp_vc);
         check($sformatf("tbl%0d_xbv", n), cap_xbv, tbl[n].exp_xbv);
      end
      check("flow_xb_vc4", xb_vc_o[4], 1);

      // Full load: every VC requests, each VC plane routed as a permutation.
      reset_pulse();
      for (int c = 0; c < 20; c++) begin
         s = $urandom_range(0, 4);
         request_i = '1;
         on_off_i  = '1;
         downstream_vc_i = 10'($urandom);
         for (int i = 0; i < 5; i++) begin
            out_port_i[i][0] = 3'((i + s) % 5);
            out_port_i[i][1] = 3'((i + s + 2) % 5);
         end
         cycle();
         check("full_grants", $countones(cap_valid), 5);
      end
      check("full_xbv_before_rst", xb_valid_o, 5'b11111);
      #2;
      rst = 1'b0;
      #1;
      check("async_xb_clear", xb_valid_o, 0);
      check("async_sel_clear", valid_sel_o, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();

      for (int c = 0; c < 300; c++) begin
         if (c == 150) reset_pulse();
         randomize_inputs();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
